matriz_alu_seq: RTL and testbench

//  Parametrised sequential matrix ALU. It is the next generation of the coprocessor's single-cycle ALU.

---
 rtl/matriz_alu_seq.sv | 211 +++++++++++++++++++++
 tb/tb_matriz_alu_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matriz_alu_seq.sv
// matriz_alu_seq
//   Sequential signed matrix ALU working on an n x n window (n = 2..DIM) of
//   DIM x DIM operands. It produces one result element per clock in row-major
//   order (a determinant takes a single element). Every result is saturated
//   to W-bit signed.
//
//   Ports
//     clk, rst            clock (rising edge); asynchronous active-high reset
//     start               level request, held high until done is seen
//     opcode              3 add, 4 sub, 5 mul, 6 transp, 7 opp, 8 esc, 9 det
//     size                active dimension n
//     data_escalar        scalar operand for esc
//     matrizA, matrizB    operands, element (r,c) at [(r*DIM+c)*W +: W]
//     matriz_resultante   result, same layout, zero outside the n x n window
//     done, busy          operation complete / calculating
//     overflow, error     any element clamped / illegal opcode or size
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   CALC  | one result element written per edge (skipped on error)
//   DONE  | result and done held until start is released
module matriz_alu_seq #(
  parameter int DIM = 5,
  parameter int W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           opcode,
  input  logic [2:0]           size,
  input  logic [W-1:0]         data_escalar,
  input  logic [DIM*DIM*W-1:0] matrizA,
  input  logic [DIM*DIM*W-1:0] matrizB,
  output logic [DIM*DIM*W-1:0] matriz_resultante,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 error
);

  localparam int BW = DIM * DIM * W;
  localparam int MW = 2 * W + 3;   // matrix-product accumulator width
  localparam int WW = 3 * W + 3;   // widest intermediate (3x3 determinant)

  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_TRN = 4'd6;
  localparam logic [3:0] OP_OPP = 4'd7;
  localparam logic [3:0] OP_ESC = 4'd8;
  localparam logic [3:0] OP_DET = 4'd9;

  localparam logic signed [WW-1:0] SAT_MAX = WW'(2 ** (W - 1) - 1);
  localparam logic signed [WW-1:0] SAT_MIN = WW'(-(2 ** (W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [3:0]          op_q;
  logic [2:0]          n_q;
  logic signed [W-1:0] esc_q;
  logic [BW-1:0]       a_q, b_q;
  logic [BW-1:0]       res_q;
  logic                ovf_q, err_q;
  logic [5:0]          idx_q;
  logic [2:0]          r_q, c_q;

  logic                illegal;
  logic [5:0]          nn;
  logic                calc_last;
  logic signed [WW-1:0] acc;
  logic signed [MW-1:0] mul_acc;
  logic signed [WW-1:0] a_rc, b_rc;
  logic signed [WW-1:0] d [3][3];
  logic signed [W-1:0]  sat_val;
  logic                 clip;

  function automatic logic signed [W-1:0] el(input logic [BW-1:0] m, input int r, input int c);
    return m[(r * DIM + c) * W +: W];
  endfunction

  always_comb begin
    illegal = 1'b0;
    if (opcode < OP_ADD || opcode > OP_DET) illegal = 1'b1;
    if (int'(size) < 2 || int'(size) > DIM) illegal = 1'b1;
    if (opcode == OP_DET && size > 3'd3) illegal = 1'b1;
  end

  // A determinant is a single element, so it always finishes after one CALC edge.
  always_comb begin
    nn        = 6'(n_q) * 6'(n_q);
    calc_last = (op_q == OP_DET) || (idx_q == nn - 6'd1);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (err_q || calc_last) state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    done = (state_q == S_DONE);
    busy = (state_q == S_CALC);
  end

  assign matriz_resultante = res_q;
  assign overflow          = ovf_q;
  assign error             = err_q;

  // Element (r_q, c_q) of the current operation, before saturation.
  always_comb begin
    acc     = '0;
    mul_acc = '0;
    a_rc    = WW'(el(a_q, int'(r_q), int'(c_q)));
    b_rc    = WW'(el(b_q, int'(r_q), int'(c_q)));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d[i][j] = WW'(el(a_q, i, j));
    case (op_q)
      OP_ADD: acc = a_rc + b_rc;
      OP_SUB: acc = a_rc - b_rc;
      OP_OPP: acc = -a_rc;
      OP_TRN: acc = WW'(el(a_q, int'(c_q), int'(r_q)));
      OP_ESC: acc = WW'(esc_q) * a_rc;
      OP_MUL: begin
        for (int j = 0; j < DIM; j++)
          if (j < int'(n_q))
            mul_acc = mul_acc + MW'(el(a_q, int'(r_q), j)) * MW'(el(b_q, j, int'(c_q)));
        acc = WW'(mul_acc);
      end
      OP_DET: begin
        if (n_q == 3'd2)
          acc = d[0][0] * d[1][1] - d[0][1] * d[1][0];
        else
          acc = d[0][0] * d[1][1] * d[2][2] + d[0][1] * d[1][2] * d[2][0]
              + d[0][2] * d[1][0] * d[2][1] - d[0][2] * d[1][1] * d[2][0]
              - d[0][0] * d[1][2] * d[2][1] - d[0][1] * d[1][0] * d[2][2];
      end
      default: acc = '0;
    endcase

    clip    = 1'b0;
    sat_val = acc[W-1:0];
    if (acc > SAT_MAX) begin
      sat_val = SAT_MAX[W-1:0];
      clip    = 1'b1;
    end else if (acc < SAT_MIN) begin
      sat_val = SAT_MIN[W-1:0];
      clip    = 1'b1;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      n_q   <= '0;
      esc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      r_q   <= '0;
      c_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          op_q  <= opcode;
          n_q   <= size;
          esc_q <= data_escalar;
          a_q   <= matrizA;
          b_q   <= matrizB;
          res_q <= '0;   // keeps everything outside the window at zero
          ovf_q <= 1'b0;
          err_q <= illegal;
          idx_q <= '0;
          r_q   <= '0;
          c_q   <= '0;
        end
        S_CALC: if (!err_q) begin
          res_q[(int'(r_q) * DIM + int'(c_q)) * W +: W] <= sat_val;
          if (clip) ovf_q <= 1'b1;
          idx_q <= idx_q + 6'd1;
          if (c_q == n_q - 3'd1) begin
            c_q <= '0;
            r_q <= r_q + 3'd1;
          end else begin
            c_q <= c_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matriz_alu_seq.sv
module tb_matriz_alu_seq;

  localparam int DIM = 5;
  localparam int W   = 8;
  localparam int BW  = DIM * DIM * W;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [3:0]     opcode;
  logic [2:0]     size;
  logic [W-1:0]   data_escalar;
  logic [BW-1:0]  matrizA, matrizB;
  logic [BW-1:0]  matriz_resultante;
  logic           done, busy, overflow, error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [BW-1:0] res;
    logic          ovf;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];

  matriz_alu_seq #(.DIM(DIM), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .size(size),
    .data_escalar(data_escalar), .matrizA(matrizA), .matrizB(matrizB),
    .matriz_resultante(matriz_resultante), .done(done), .busy(busy),
    .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  // ---------------- helpers / reference model ----------------
  function automatic logic [BW-1:0] put(input logic [BW-1:0] m, input int r, input int c, input int v);
    logic [BW-1:0] t;
    t = m;
    t[(r * DIM + c) * W +: W] = v[W-1:0];
    return t;
  endfunction

  function automatic int ga(input logic [BW-1:0] m, input int r, input int c);
    logic [W-1:0] e;
    e = m[(r * DIM + c) * W +: W];
    return int'($signed(e));
  endfunction

  function automatic logic [BW-1:0] mat(input int n, input int v[]);
    logic [BW-1:0] m;
    m = '0;
    for (int i = 0; i < n * n; i++) m = put(m, i / n, i % n, v[i]);
    return m;
  endfunction

  function automatic logic [BW-1:0] rand_mat(input int lim);
    logic [BW-1:0] m;
    m = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        m = put(m, r, c, int'($urandom_range(0, 2 * lim)) - lim);
    return m;
  endfunction

  function automatic logic [BW-1:0] model(input logic [3:0] op, input int n, input int esc,
                                          input logic [BW-1:0] a, input logic [BW-1:0] b,
                                          output logic ovf, output logic err);
    logic [BW-1:0] res;
    int v, hi, lo;
    res = '0;
    hi  = (1 << (W - 1)) - 1;
    lo  = -(1 << (W - 1));
    ovf = 1'b0;
    err = (op < 4'd3) || (op > 4'd9) || (n < 2) || (n > DIM) || (op == 4'd9 && n > 3);
    if (err) return res;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        v = 0;
        case (op)
          4'd3: v = ga(a, r, c) + ga(b, r, c);
          4'd4: v = ga(a, r, c) - ga(b, r, c);
          4'd5: for (int j = 0; j < n; j++) v += ga(a, r, j) * ga(b, j, c);
          4'd6: v = ga(a, c, r);
          4'd7: v = -ga(a, r, c);
          4'd8: v = esc * ga(a, r, c);
          default: begin
            if (n == 2)
              v = ga(a, 0, 0) * ga(a, 1, 1) - ga(a, 0, 1) * ga(a, 1, 0);
            else  // cofactor expansion along row 0
              v = ga(a, 0, 0) * (ga(a, 1, 1) * ga(a, 2, 2) - ga(a, 1, 2) * ga(a, 2, 1))
                - ga(a, 0, 1) * (ga(a, 1, 0) * ga(a, 2, 2) - ga(a, 1, 2) * ga(a, 2, 0))
                + ga(a, 0, 2) * (ga(a, 1, 0) * ga(a, 2, 1) - ga(a, 1, 1) * ga(a, 2, 0));
          end
        endcase
        if (op == 4'd9 && (r != 0 || c != 0)) continue;
        if (v > hi) begin v = hi; ovf = 1'b1; end
        if (v < lo) begin v = lo; ovf = 1'b1; end
        res = put(res, r, c, v);
      end
    return res;
  endfunction

  function automatic exp_t expect_of(input logic [3:0] op, input int n, input int esc,
                                     input logic [BW-1:0] a, input logic [BW-1:0] b);
    exp_t e;
    logic o, er;
    e.res = model(op, n, esc, a, b, o, er);
    e.ovf = o;
    e.err = er;
    e.lat = (er || op == 4'd9) ? 1 : n * n;
    return e;
  endfunction

  // Issue one operation, hold start for 'hold' cycles in DONE, then release.
  task automatic run_op(input string name, input logic [3:0] op, input int n, input int esc,
                        input logic [BW-1:0] a, input logic [BW-1:0] b, input int hold);
    exp_t e;
    int cnt;
    sb.push_back(expect_of(op, n, esc, a, b));
    @(negedge clk);
    opcode = op; size = 3'(n); data_escalar = esc[W-1:0];
    matrizA = a; matrizB = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // operands must have been latched; disturb the inputs
    opcode = 4'd0; size = 3'd7; data_escalar = ~data_escalar; matrizA = ~a; matrizB = ~b;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy: got %b want 1", name, busy);
    end
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s timeout: done never rose", name);
    end
    checks++;
    if (cnt != e.lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cnt, e.lat);
    end
    checks++;
    if (matriz_resultante !== e.res) begin
      errors++; $display("FAIL %s result: got %h want %h", name, matriz_resultante, e.res);
    end
    checks++;
    if (overflow !== e.ovf) begin
      errors++; $display("FAIL %s overflow: got %b want %b", name, overflow, e.ovf);
    end
    checks++;
    if (error !== e.err) begin
      errors++; $display("FAIL %s error: got %b want %b", name, error, e.err);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || matriz_resultante !== e.res) begin
        errors++; $display("FAIL %s hold: done=%b busy=%b res=%h want done=1 busy=0 res=%h",
                           name, done, busy, matriz_resultante, e.res);
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s release: done=%b busy=%b want 0 0", name, done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = '0; size = '0; data_escalar = '0;
    matrizA = '0; matrizB = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL reset flags: done=%b busy=%b ovf=%b err=%b want 0000",
                         done, busy, overflow, error);
    end
    checks++;
    if (matriz_resultante !== '0) begin
      errors++; $display("FAIL reset result: got %h want 0", matriz_resultante);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    run_op("add2", 4'd3, 2, 0, mat(2, '{1, 2, 3, 4}), mat(2, '{5, 6, 7, 8}), 0);
    run_op("sub3", 4'd4, 3, 0, mat(3, '{9, -8, 7, 6, 5, 4, 3, 2, 1}),
           mat(3, '{1, 2, 3, 4, 5, 6, 7, 8, 9}), 0);
  endtask

  task automatic test_mul();
    run_op("mul_id3", 4'd5, 3, 0, mat(3, '{1, 0, 0, 0, 1, 0, 0, 0, 1}),
           mat(3, '{1, 2, 3, 4, 5, 6, 7, 8, 9}), 0);
    run_op("mul_ones5", 4'd5, 5, 0, {BW/W{8'sd1}}, {BW/W{8'sd1}}, 0);
  endtask

  task automatic test_saturation();
    run_op("add_sat", 4'd3, 2, 0, mat(2, '{100, 1, 2, 3}), mat(2, '{100, 1, 1, 1}), 0);
    run_op("opp_sat", 4'd7, 2, 0, mat(2, '{-128, 5, -7, 0}), '0, 0);
    run_op("esc", 4'd8, 2, -3, mat(2, '{4, -2, 0, 1}), '0, 0);
    run_op("esc_sat", 4'd8, 2, -3, mat(2, '{4, -2, 0, 50}), '0, 0);
    run_op("transp4", 4'd6, 4, 0, rand_mat(100), rand_mat(100), 0);
  endtask

  task automatic test_det();
    run_op("det3", 4'd9, 3, 0, mat(3, '{2, 0, 1, 1, 3, 2, 1, 1, 1}), '0, 0);
    run_op("det2", 4'd9, 2, 0, mat(2, '{7, 3, 2, 5}), '0, 0);
    run_op("det3_sat", 4'd9, 3, 0, mat(3, '{10, 0, 0, 0, 10, 0, 0, 0, 10}), '0, 0);
    run_op("det4_err", 4'd9, 4, 0, rand_mat(9), '0, 0);
  endtask

  task automatic test_illegal();
    run_op("op0_err", 4'd0, 3, 0, rand_mat(9), rand_mat(9), 0);
    run_op("op10_err", 4'd10, 3, 0, rand_mat(9), rand_mat(9), 0);
    run_op("size1_err", 4'd3, 1, 0, rand_mat(9), rand_mat(9), 0);
    run_op("size6_err", 4'd3, 6, 0, rand_mat(9), rand_mat(9), 0);
  endtask

  task automatic test_random();
    logic [3:0] ops [6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    for (int i = 0; i < 8; i++)
      run_op("random", ops[$urandom_range(0, 5)], int'($urandom_range(2, DIM)),
             int'($urandom_range(0, 20)) - 10, rand_mat(30), rand_mat(30), 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    opcode = 4'd5; size = 3'd5; matrizA = rand_mat(10); matrizB = rand_mat(10); start = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid busy before: got %b want 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || matriz_resultante !== '0) begin
      errors++; $display("FAIL reset_mid async: done=%b busy=%b res=%h want 0 0 0",
                         done, busy, matriz_resultante);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_reset", 4'd3, 2, 0, mat(2, '{1, 2, 3, 4}), mat(2, '{5, 6, 7, 8}), 0);
  endtask

  task automatic test_start_drop();
    exp_t e;
    logic [BW-1:0] a, b;
    int cnt, high;
    a = rand_mat(20); b = rand_mat(20);
    sb.push_back(expect_of(4'd3, 3, 0, a, b));
    @(negedge clk);
    opcode = 4'd3; size = 3'd3; matrizA = a; matrizB = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    e = sb.pop_front();
    checks++;
    if (cnt != e.lat || matriz_resultante !== e.res) begin
      errors++; $display("FAIL start_drop op: lat=%0d res=%h want lat=%0d res=%h",
                         cnt, matriz_resultante, e.lat, e.res);
    end
    high = 0;
    while (done === 1'b1 && high < 10) begin
      @(negedge clk); high++;
    end
    checks++;
    if (high != 1) begin
      errors++; $display("FAIL start_drop done width: got %0d cycles want 1", high);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_drop idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_hold", 4'd4, 2, 0, mat(2, '{-100, 50, 0, 1}), mat(2, '{100, -100, 0, 1}), 4);
    run_op("b2b_next", 4'd8, 5, 2, rand_mat(50), '0, 2);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_saturation();
    test_det();
    test_illegal();
    test_random();
    test_reset_mid();
    test_start_drop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
